mem_port_ctrl: RTL and testbench

- Sits directly downstream of the LC-3b datapath's MAR/MDR outputs, between the datapath/control pair and the physical memory port.
- Accepts one read or write request at a time from the control FSM and drives mem_read/mem_write/mem_byte_enable until mem_resp arrives.
- Returns a one-cycle done pulse and registered read data, with byte-lane steering for LDB/STB.
- A watchdog flags a memory that never responds.

---
 rtl/mem_port_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_port_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// Memory port controller: one read/write at a time, byte-lane steering, watchdog abort.
// Latency: strobe the cycle after the request edge; done the cycle after mem_resp (min 2 cycles).
// Backpressure: requests are ignored while busy; control must hold or reissue them.
module mem_port_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] wdog, wdog_nxt;
    logic        byte_q, byte_nxt;
    logic        lane_q, lane_nxt;
    logic [15:0] rdata_nxt, mem_address_nxt, mem_wdata_nxt;
    logic        done_nxt, busy_nxt, timeout_err_nxt;
    logic        mem_read_nxt, mem_write_nxt;
    logic [1:0]  be_nxt;
    logic [15:0] rd_steered;

    always_comb begin
        rd_steered = mem_rdata;
        if (byte_q) begin
            rd_steered = lane_q ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            wdog            <= '0;
            byte_q          <= 1'b0;
            lane_q          <= 1'b0;
            rdata           <= '0;
            done            <= 1'b0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= 2'b00;
        end else begin
            state           <= state_nxt;
            wdog            <= wdog_nxt;
            byte_q          <= byte_nxt;
            lane_q          <= lane_nxt;
            rdata           <= rdata_nxt;
            done            <= done_nxt;
            busy            <= busy_nxt;
            timeout_err     <= timeout_err_nxt;
            mem_address     <= mem_address_nxt;
            mem_wdata       <= mem_wdata_nxt;
            mem_read        <= mem_read_nxt;
            mem_write       <= mem_write_nxt;
            mem_byte_enable <= be_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wdog_nxt        = wdog;
        byte_nxt        = byte_q;
        lane_nxt        = lane_q;
        rdata_nxt       = rdata;
        done_nxt        = 1'b0;
        busy_nxt        = busy;
        timeout_err_nxt = timeout_err;
        mem_address_nxt = mem_address;
        mem_wdata_nxt   = mem_wdata;
        mem_read_nxt    = mem_read;
        mem_write_nxt   = mem_write;
        be_nxt          = mem_byte_enable;

        unique case (state)
            ST_IDLE: begin
                if (req_read || req_write) begin
                    state_nxt       = req_read ? ST_READ : ST_WRITE;
                    mem_read_nxt    = req_read;
                    mem_write_nxt   = !req_read;
                    busy_nxt        = 1'b1;
                    wdog_nxt        = '0;
                    byte_nxt        = req_byte;
                    lane_nxt        = addr[0];
                    mem_address_nxt = {addr[15:1], 1'b0};
                    if (req_byte) begin
                        be_nxt        = addr[0] ? 2'b10 : 2'b01;
                        mem_wdata_nxt = {wdata[7:0], wdata[7:0]};
                    end else begin
                        be_nxt        = 2'b11;
                        mem_wdata_nxt = wdata;
                    end
                end
            end
            ST_READ, ST_WRITE: begin
                // A response on the expiry cycle still wins over the watchdog.
                if (mem_resp) begin
                    state_nxt     = ST_DONE;
                    done_nxt      = 1'b1;
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    be_nxt        = 2'b00;
                    if (state == ST_READ) begin
                        rdata_nxt = rd_steered;
                    end
                end else if (wdog == WDOG_LAST) begin
                    state_nxt       = ST_DONE;
                    done_nxt        = 1'b1;
                    timeout_err_nxt = 1'b1;
                    mem_read_nxt    = 1'b0;
                    mem_write_nxt   = 1'b0;
                    be_nxt          = 2'b00;
                end else begin
                    wdog_nxt = wdog + 16'd1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                wdog_nxt  = '0;
                be_nxt    = 2'b00;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: table of single transactions plus corner-case sequences.
module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_read = 1'b0, req_write = 1'b0, req_byte = 1'b0;
    logic [15:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic [15:0] rdata, mem_address, mem_wdata;
    logic        done, busy, timeout_err, mem_read, mem_write;
    logic [1:0]  mem_byte_enable;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_read(req_read), .req_write(req_write), .req_byte(req_byte),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .done(done), .busy(busy), .timeout_err(timeout_err),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic        bt;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] mrd;
        int          d;
        logic [15:0] e_addr;
        logic [1:0]  e_be;
        logic [15:0] e_wd;
        logic [15:0] e_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, answer it after d strobe cycles, check strobes, data and the done pulse.
    task automatic run_txn(input string tag, input logic rd, input logic wr, input logic bt,
                           input logic [15:0] a, input logic [15:0] wd, input logic [15:0] mrd,
                           input int d, input logic [15:0] e_addr, input logic [1:0] e_be,
                           input logic [15:0] e_wd, input logic [15:0] e_rd, input logic e_te);
        int good = 0;
        int bad = 0;
        logic exp_read;
        exp_read  = rd;
        req_read  = rd;
        req_write = wr;
        req_byte  = bt;
        addr      = a;
        wdata     = wd;
        tick();
        req_read  = 1'b0;
        req_write = 1'b0;
        chk({tag, "_addr"}, 32'(mem_address), 32'(e_addr));
        chk({tag, "_be"}, 32'(mem_byte_enable), 32'(e_be));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'(e_wd));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < d; i++) begin
            if (exp_read ? mem_read : mem_write) good++;
            if (exp_read ? mem_write : mem_read) bad++;
            if (i == d - 1) begin
                mem_resp  = 1'b1;
                mem_rdata = mrd;
            end
            tick();
            mem_resp = 1'b0;
        end
        chk({tag, "_strobe_cycles"}, 32'(good), 32'(d));
        chk({tag, "_wrong_strobe"}, 32'(bad), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_strobe_drop"}, 32'({mem_read, mem_write}), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'(e_rd));
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(e_te));
        tick();
        chk({tag, "_done_once"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_be_clear"}, 32'(mem_byte_enable), 32'd0);
    endtask

    initial begin
        int n;
        int cnt;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0031, 16'h0000, 16'hBEEF, 3, 16'h0030, 2'b11, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h1003, 16'h0000, 16'hA55A, 1, 16'h1002, 2'b10, 16'h0000, 16'h00A5};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h1002, 16'h0000, 16'hA55A, 2, 16'h1002, 2'b01, 16'h0000, 16'h005A};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h2001, 16'h1234, 16'hFFFF, 2, 16'h2000, 2'b10, 16'h3434, 16'h005A};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h4444, 16'hCAFE, 16'h0000, 1, 16'h4444, 2'b11, 16'hCAFE, 16'h005A};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h00AB, 16'h0000, 4, 16'h0010, 2'b01, 16'hABAB, 16'h005A};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'hFFFF, 16'h1357, 2, 16'h0100, 2'b11, 16'hFFFF, 16'h1357};

        repeat (2) tick();
        chk("reset_outputs", {rdata, 5'(0), done, busy, timeout_err, mem_read, mem_write, mem_byte_enable, 4'(0)}, 32'd0);
        chk("reset_addr_wdata", {mem_address, mem_wdata}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].bt, vecs[i].a,
                    vecs[i].wd, vecs[i].mrd, vecs[i].d, vecs[i].e_addr, vecs[i].e_be,
                    vecs[i].e_wd, vecs[i].e_rd, 1'b0);
        end

        // Read and write together: read wins; a write pulsed while busy is dropped.
        req_read = 1'b1; req_write = 1'b1; req_byte = 1'b0; addr = 16'h0050;
        tick();
        req_read = 1'b0; req_write = 1'b0;
        chk("both_req_read", 32'({mem_read, mem_write}), 32'b10);
        req_write = 1'b1;
        tick();
        req_write = 1'b0;
        mem_resp = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_resp = 1'b0;
        chk("both_req_done", 32'(done), 32'd1);
        chk("both_req_rdata", 32'(rdata), 32'h7777);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy || mem_write || mem_read) cnt++;
        end
        chk("busy_write_ignored", 32'(cnt), 32'd0);

        // mem_resp held high from IDLE through DONE completes exactly one read.
        req_read = 1'b1; addr = 16'h0060; mem_resp = 1'b1; mem_rdata = 16'h1111;
        tick();
        req_read = 1'b0;
        chk("held_resp_strobe", 32'(mem_read), 32'd1);
        tick();
        chk("held_resp_done", 32'(done), 32'd1);
        chk("held_resp_rdata", 32'(rdata), 32'h1111);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done || busy) cnt++;
        end
        chk("held_resp_single", 32'(cnt), 32'd0);
        mem_resp = 1'b0;
        tick();

        // Watchdog: no response at all.
        req_read = 1'b1; addr = 16'h0200;
        tick();
        req_read = 1'b0;
        n = 0;
        while (mem_read && n < 40) begin
            n++;
            tick();
        end
        chk("timeout_strobe_cycles", 32'(n), 32'd8);
        chk("timeout_done", 32'(done), 32'd1);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        chk("timeout_rdata_kept", 32'(rdata), 32'h1111);
        tick();
        chk("timeout_idle", 32'(busy), 32'd0);
        run_txn("after_timeout", 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h4242, 2,
                16'h0300, 2'b11, 16'h0000, 16'h4242, 1'b1);

        // Async reset while the read strobe is up.
        req_read = 1'b1; addr = 16'h0400;
        tick();
        req_read = 1'b0;
        chk("midreset_strobe_up", 32'(mem_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_strobe_drop", 32'(mem_read), 32'd0);
        chk("midreset_outputs", {rdata, 5'(0), done, busy, timeout_err, mem_read, mem_write, mem_byte_enable, 4'(0)}, 32'd0);
        chk("midreset_addr", 32'(mem_address), 32'd0);
        tick();
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || busy) cnt++;
        end
        chk("midreset_no_done", 32'(cnt), 32'd0);
        run_txn("after_reset", 1'b0, 1'b1, 1'b0, 16'h0801, 16'h5A5A, 16'h0000, 1,
                16'h0800, 2'b11, 16'h5A5A, 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
